// File: rtl/asmd_divider.sv
// Restoring shift-subtract divider: 2w/w -> w quotient and w remainder.
// Optional done pulse under `ASMD_DIVIDER_DONE_PULSE_EN.
module asmd_divider #(
  parameter int word_length = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [2*word_length-1:0]   dividend,
  input  logic [word_length-1:0]     divisor,
  output logic [word_length-1:0]     quotient,
  output logic [word_length-1:0]     remainder,
  output logic                       ready,
  output logic                       overflow,
  output logic                       div_by_zero,
  output logic                       done
);

  localparam int W  = word_length;
  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    ITER
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   d_q, d_d;
  logic [W:0]     r_q, r_d;
  logic [W-1:0]   q_q, q_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   quot_q, quot_d;
  logic [W-1:0]   rem_q, rem_d;
  logic           ovf_q, ovf_d;
  logic           dbz_q, dbz_d;
  logic           fin;

  logic [2*W:0]   rq_sh;
  logic [W:0]     r_sh;
  logic [W-1:0]   q_sh;
  logic [W:0]     d_ext;
  logic           r_ge;

  // Partial remainder stays below D before each shift, so the
  // (w+1)-bit shifted value never loses its top bit.
  assign rq_sh = {r_q, q_q} << 1;
  assign r_sh  = rq_sh[2*W:W];
  assign q_sh  = rq_sh[W-1:0];
  assign d_ext = {1'b0, d_q};
  assign r_ge  = (r_sh >= d_ext);

  always_comb begin
    state_d = state_q;
    d_d     = d_q;
    r_d     = r_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    ovf_d   = ovf_q;
    dbz_d   = dbz_q;
    fin     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          d_d     = divisor;
          r_d     = {1'b0, dividend[2*W-1:W]};
          q_d     = dividend[W-1:0];
          ovf_d   = 1'b0;
          dbz_d   = 1'b0;
          state_d = CHECK;
        end
      end

      CHECK: begin
        if (d_q == '0) begin
          dbz_d   = 1'b1;
          ovf_d   = 1'b1;
          quot_d  = '1;
          rem_d   = '0;
          fin     = 1'b1;
          state_d = IDLE;
        end else if (r_q >= d_ext) begin
          ovf_d   = 1'b1;
          quot_d  = '1;
          rem_d   = '0;
          fin     = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d   = CW'(W);
          state_d = ITER;
        end
      end

      ITER: begin
        if (r_ge) begin
          r_d = r_sh - d_ext;
          q_d = {q_sh[W-1:1], 1'b1};
        end else begin
          r_d = r_sh;
          q_d = q_sh;
        end
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          quot_d  = q_d;
          rem_d   = r_d[W-1:0];
          fin     = 1'b1;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      d_q     <= '0;
      r_q     <= '0;
      q_q     <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      ovf_q   <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      d_q     <= d_d;
      r_q     <= r_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      ovf_q   <= ovf_d;
      dbz_q   <= dbz_d;
    end
  end

`ifdef ASMD_DIVIDER_DONE_PULSE_EN
  logic done_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done_q <= 1'b0;
    end else begin
      done_q <= fin;
    end
  end

  assign done = done_q;
`else
  logic unused_fin;

  assign unused_fin = fin;
  assign done       = 1'b0;
`endif

  assign ready       = (state_q == IDLE);
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign overflow    = ovf_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_asmd_divider.sv
// Directed self-checking bench for asmd_divider (word_length = 4).
// Outputs are sampled 1 ns after each rising edge.
module tb_asmd_divider;

  localparam int W = 4;

`ifdef ASMD_DIVIDER_DONE_PULSE_EN
  localparam logic DONE_EXP = 1'b1;
`else
  localparam logic DONE_EXP = 1'b0;
`endif

  logic           clk;
  logic           reset;
  logic           start;
  logic [2*W-1:0] dividend;
  logic [W-1:0]   divisor;
  logic [W-1:0]   quotient;
  logic [W-1:0]   remainder;
  logic           ready;
  logic           overflow;
  logic           div_by_zero;
  logic           done;

  int total = 0;
  int bad   = 0;

  asmd_divider #(.word_length(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .ready       (ready),
    .overflow    (overflow),
    .div_by_zero (div_by_zero),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Launch one op on the next edge; n counts edges E0..completion.
  task automatic run_div(
    input string      tag,
    input int         dd,
    input int         dv,
    input int         lat,
    input int         eq,
    input int         er,
    input int         eovf,
    input int         edbz
  );
    int n;
    @(negedge clk);
    dividend = 8'(dd);
    divisor  = 4'(dv);
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    n = 1;
    while (ready !== 1'b1 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, "_lat"}, n, lat);
    chk({tag, "_q"}, int'(quotient), eq);
    chk({tag, "_r"}, int'(remainder), er);
    chk({tag, "_ovf"}, int'(overflow), eovf);
    chk({tag, "_dbz"}, int'(div_by_zero), edbz);
    chk({tag, "_done"}, int'(done), int'(DONE_EXP));
    @(posedge clk);
    #1;
    chk({tag, "_done_end"}, int'(done), 0);
  endtask

  initial begin
    int n;
    reset    = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;

    #10;
    chk("rst_ready", int'(ready), 1);
    chk("rst_q", int'(quotient), 0);
    chk("rst_r", int'(remainder), 0);
    chk("rst_ovf", int'(overflow), 0);
    chk("rst_done", int'(done), 0);
    #10;
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_ready", int'(ready), 1);

    run_div("d20_5", 20, 5, 6, 4, 0, 0, 0);
    run_div("d225_15", 225, 15, 6, 15, 0, 0, 0);
    run_div("d200_15", 200, 15, 6, 13, 5, 0, 0);
    run_div("d157_13", 157, 13, 6, 12, 1, 0, 0);
    run_div("dbz", 8'h37, 0, 2, 15, 0, 1, 1);
    run_div("ovf", 8'h50, 4, 2, 15, 0, 1, 0);
    run_div("d3_7", 3, 7, 6, 0, 3, 0, 0);

    // Inputs and start changing mid-operation must be ignored.
    @(negedge clk);
    dividend = 8'd200;
    divisor  = 4'd15;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rob_busy", int'(ready), 0);
    chk("rob_hold_q", int'(quotient), 0);
    chk("rob_hold_r", int'(remainder), 3);
    dividend = 8'h37;
    divisor  = 4'd0;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    n = 4;
    while (ready !== 1'b1 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("rob_lat", n, 6);
    chk("rob_q", int'(quotient), 13);
    chk("rob_r", int'(remainder), 5);
    chk("rob_dbz", int'(div_by_zero), 0);
    @(posedge clk);
    #1;
    chk("rob_no_requeue", int'(ready), 1);

    // Reset in the middle of an iteration.
    @(negedge clk);
    dividend = 8'd20;
    divisor  = 4'd5;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("mid_rst_ready", int'(ready), 1);
    chk("mid_rst_q", int'(quotient), 0);
    chk("mid_rst_r", int'(remainder), 0);
    chk("mid_rst_ovf", int'(overflow), 0);
    @(negedge clk);
    reset = 1'b0;
    run_div("after_rst", 20, 5, 6, 4, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/asmd_divider.md
# asmd_divider

Sequential restoring (shift-subtract) divider built as an ASMD controller plus datapath. It is the inverse companion of `asmd_multiplier`: it takes a double-width dividend of the kind the multiplier produces and a single-width divisor, and returns quotient and remainder. It uses the same `start`/`ready` handshake, and shares the multiplier's `word_length` parameterisation so the two blocks drop side by side into the arithmetic datapath.

## Interface
- `word_length`, default 4, operand width; the dividend is `2*word_length` bits.

- `clk`  in  1  system clock, rising-edge active
- `reset`  in  1  asynchronous, active-high reset
- `start`  in  1  request; sampled only in IDLE
- `dividend`  in  2*word_length  numerator; sampled on the accepting edge
- `divisor`  in  word_length  denominator; sampled on the accepting edge
- `quotient`  out  word_length  registered result
- `remainder`  out  word_length  registered result
- `ready`  out  1  high in IDLE (Moore output)
- `overflow`  out  1  quotient does not fit in `word_length` bits, or divisor is zero
- `div_by_zero`  out  1  divisor was zero
- `done`  out  1  one-cycle completion pulse; see Configuration

## Operation
- States: IDLE, CHECK, ITER.
- IDLE:
  - `ready`=1.
  - On `start`=1, latch `divisor` to D, `dividend[2w-1:w]` to R (w+1 bits), and `dividend[w-1:0]` to Q.
  - Clear `overflow` and `div_by_zero`, then go to CHECK.
- CHECK:
  - If D==0: `div_by_zero`=1, `overflow`=1, `quotient`=all ones, `remainder`=0, go to IDLE.
  - Else if R>=D: `overflow`=1, `quotient`=all ones, `remainder`=0, go to IDLE.
  - Else: load counter=w and go to ITER.
- ITER, each cycle:
  - {R,Q} <= {R,Q}<<1.
  - If the shifted R>=D, subtract D from R and set Q[0]=1.
  - Decrement the counter. At 0, copy Q to `quotient` and R[w-1:0] to `remainder`, then go to IDLE.
- R is w+1 bits wide so the shifted partial remainder (< 2·D) never truncates. The final remainder is always < D.
- `start` outside IDLE is ignored. It is not queued.
- Input changes after the accepting edge have no effect on the operation in flight.
- `quotient`/`remainder` change only at completion. They hold the previous result while busy.
- Reset (async, any state) forces IDLE. All registers and outputs clear to 0, except `ready`=1. An operation in flight is discarded.
- Reset values: `quotient`=0, `remainder`=0, `ready`=1, `overflow`=0, `div_by_zero`=0, `done`=0.

## Timing
- Edge E0 (`start` accepted): `ready` falls after E0.
- Normal divide:
  - CHECK evaluates at E1.
  - Iterations occupy E2..E(w+1).
  - Results and `ready`=1 are visible after E(w+1).
  - Latency is w+2 cycles (6 for w=4).
- Error path: flags, results and `ready`=1 are visible after E1 (2 cycles).
- A new `start` may be accepted on the first edge with `ready`=1. This gives back-to-back throughput of one op per w+2 cycles.
- `start` held high continuously restarts immediately on every return to IDLE.
- No combinational path from inputs to outputs.

## Configuration
- Macro `ASMD_DIVIDER_DONE_PULSE_EN`.
- Defined: `done` is a registered pulse, high for exactly the one cycle after the completing edge. This applies to normal and error paths; a normal divide with w=4 gives `done`=1 after E5.
- Undefined: `done` is tied to 0 and the pulse register is not synthesized. All other behaviour is identical.

## Test plan
- Reset asserted 20 ns, then released:
  - during reset, `ready`=1 and `quotient`=`remainder`=0;
  - after release, `ready` stays 1.
- w=4, dividend=20, divisor=5, 1-cycle start pulse:
  - `ready` low for exactly 6 cycles;
  - then `quotient`=4, `remainder`=0, `overflow`=0;
  - with the macro defined, `done` pulses once.
- Basic divides:
  - dividend=225, divisor=15 → `quotient`=15, `remainder`=0.
  - dividend=200, divisor=15 → `quotient`=13, `remainder`=5.
- Divide by zero: dividend=0x37, divisor=0 → after 2 cycles, `div_by_zero`=1, `overflow`=1, `quotient`=15, `remainder`=0.
- Quotient overflow: dividend=0x50, divisor=4 → `overflow`=1, `div_by_zero`=0, 2-cycle latency.
- Robustness:
  - change `dividend`/`divisor` and pulse `start` during ITER → ignored, and the original result is returned.
  - assert `reset` mid-ITER → immediate IDLE with cleared outputs; the next divide 20/5 yields 4 r 0.
